// File: rtl/hello_world_qsys_button_ctrl_if.sv
// Avalon-MM slave bus bundle for the push-button controller.
//   address    : 2-bit word address
//   chipselect : slave select, qualifies read/write
//   read/write : access strobes
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (driven by the slave)
interface hello_world_qsys_button_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/hello_world_qsys_button_ctrl.sv
// Push-button controller: debounces active-low button pins and turns them into press and
// auto-repeat events, exposed through a 4-word Avalon-MM register file with a level interrupt.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   avs     : Avalon-MM slave (0 LEVEL ro, 1 IRQ_MASK rw, 2 EVENT rw1c, 3 HELD ro)
//   in_port : raw button pins, active-low, asynchronous
//   irq     : registered interrupt, |(event & mask)
module hello_world_qsys_button_ctrl #(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  hello_world_qsys_button_ctrl_if.slave avs,
  input  logic [NUM_BUTTONS-1:0]       in_port,
  output logic                         irq
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax);

  localparam logic [DbW-1:0]  DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RepW-1:0] DelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] PeriodLast = RepW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] StReleased = 2'd0;
  localparam logic [1:0] StPressed  = 2'd1;
  localparam logic [1:0] StRepeat   = 2'd2;

  // Input synchronizer (after inversion, so 1 = pressed)
  logic [NUM_BUTTONS-1:0] sync1_q, sync_q;

  // Debounce
  logic [NUM_BUTTONS-1:0] stable_q, stable_d;
  logic [DbW-1:0]         db_cnt_q [NUM_BUTTONS];
  logic [DbW-1:0]         db_cnt_d [NUM_BUTTONS];

  // Press / repeat FSMs
  logic [1:0]             state_q   [NUM_BUTTONS];
  logic [1:0]             state_d   [NUM_BUTTONS];
  logic [RepW-1:0]        rep_cnt_q [NUM_BUTTONS];
  logic [RepW-1:0]        rep_cnt_d [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] ev_set;
  logic [NUM_BUTTONS-1:0] held;

  // Registers
  logic [NUM_BUTTONS-1:0] evt_q, evt_d;
  logic [NUM_BUTTONS-1:0] mask_q, mask_d;
  logic [NUM_BUTTONS-1:0] ev_clr;
  logic [31:0]            readdata_q, readdata_d;
  logic                   irq_q;

  logic wr_en, rd_en;
  logic unused_wdata;

  assign wr_en = avs.chipselect & avs.write;
  assign rd_en = avs.chipselect & avs.read;

  // Only the low NUM_BUTTONS bits of writedata carry meaning.
  assign unused_wdata = ^avs.writedata[31:NUM_BUTTONS];

  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      // Debounce: count consecutive mismatching cycles, accept after DEBOUNCE_CYCLES of them.
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = '0;
      if (sync_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          stable_d[i] = sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end

      // Press / repeat FSM; release wins over counter expiry.
      state_d[i]   = state_q[i];
      rep_cnt_d[i] = rep_cnt_q[i];
      ev_set[i]    = 1'b0;
      case (state_q[i])
        StReleased: begin
          rep_cnt_d[i] = '0;
          if (stable_q[i]) begin
            ev_set[i]  = 1'b1;
            state_d[i] = StPressed;
          end
        end
        StPressed: begin
          if (!stable_q[i]) begin
            state_d[i]   = StReleased;
            rep_cnt_d[i] = '0;
          end else if (rep_cnt_q[i] == DelayLast) begin
            ev_set[i]    = 1'b1;
            rep_cnt_d[i] = '0;
            state_d[i]   = StRepeat;
          end else begin
            rep_cnt_d[i] = rep_cnt_q[i] + RepW'(1);
          end
        end
        StRepeat: begin
          if (!stable_q[i]) begin
            state_d[i]   = StReleased;
            rep_cnt_d[i] = '0;
          end else if (rep_cnt_q[i] == PeriodLast) begin
            ev_set[i]    = 1'b1;
            rep_cnt_d[i] = '0;
          end else begin
            rep_cnt_d[i] = rep_cnt_q[i] + RepW'(1);
          end
        end
        default: begin
          state_d[i]   = StReleased;
          rep_cnt_d[i] = '0;
        end
      endcase

      held[i] = (state_q[i] == StRepeat);
    end
  end

  // Register writes; a same-cycle set beats a write-1-to-clear.
  always_comb begin
    ev_clr = '0;
    mask_d = mask_q;
    if (wr_en && (avs.address == 2'd2)) begin
      ev_clr = avs.writedata[NUM_BUTTONS-1:0];
    end
    if (wr_en && (avs.address == 2'd1)) begin
      mask_d = avs.writedata[NUM_BUTTONS-1:0];
    end
    evt_d = (evt_q & ~ev_clr) | ev_set;
  end

  // Read mux; readdata only reloads on a read so it holds between accesses.
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d = '0;
      case (avs.address)
        2'd0:    readdata_d[NUM_BUTTONS-1:0] = stable_q;
        2'd1:    readdata_d[NUM_BUTTONS-1:0] = mask_q;
        2'd2:    readdata_d[NUM_BUTTONS-1:0] = evt_q;
        default: readdata_d[NUM_BUTTONS-1:0] = held;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync_q     <= '0;
      stable_q   <= '0;
      evt_q      <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt_q[i]  <= '0;
        state_q[i]   <= StReleased;
        rep_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= ~in_port;
      sync_q     <= sync1_q;
      stable_q   <= stable_d;
      evt_q      <= evt_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      irq_q      <= |(evt_q & mask_q);
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        state_q[i]   <= state_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end

  assign avs.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_hello_world_qsys_button_ctrl.sv
module tb_hello_world_qsys_button_ctrl;
  localparam int unsigned NB  = 4;
  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 20;
  localparam int unsigned RP  = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] in_port = '1;
  logic          irq;
  logic [NB-1:0] pressed = '0;

  hello_world_qsys_button_ctrl_if bus ();

  hello_world_qsys_button_ctrl #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .avs    (bus),
    .in_port(in_port),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit mon_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Button behaviour from timestamps: a level is accepted once the synchronized input has
  // disagreed with it for DEB edges; events fire at press+0 and press+RD+k*RP while held.
  int unsigned   cyc_n = 0;
  logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_mask = '0, m_event = '0, m_held = '0;
  logic          m_irq = 1'b0;
  bit            diffing    [NB];
  int unsigned   diff_start [NB];
  int unsigned   rise_edge  [NB];
  logic [31:0]   exp_q[$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_mask = '0; m_event = '0; m_held = '0;
    m_irq = 1'b0;
    for (int i = 0; i < NB; i++) diffing[i] = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [NB-1:0] o_stable, o_event, o_mask, o_s2, set, clr;
    logic [31:0]   v;
    cyc_n++;
    o_stable = m_stable; o_event = m_event; o_mask = m_mask; o_s2 = m_s2;
    if (bus.chipselect && bus.read) begin
      v = '0;
      case (bus.address)
        2'd0:    v[NB-1:0] = o_stable;
        2'd1:    v[NB-1:0] = o_mask;
        2'd2:    v[NB-1:0] = o_event;
        default: v[NB-1:0] = m_held;
      endcase
      exp_q.push_back(v);
    end
    set = '0;
    for (int i = 0; i < NB; i++) begin
      if (o_stable[i]) begin
        int unsigned d;
        d = cyc_n - rise_edge[i] - 1;
        if (d == 0 || (d >= RD && ((d - RD) % RP) == 0)) set[i] = 1'b1;
        m_held[i] = (d >= RD);
      end else begin
        m_held[i] = 1'b0;
      end
      if (o_s2[i] != o_stable[i]) begin
        if (!diffing[i]) begin
          diffing[i] = 1'b1;
          diff_start[i] = cyc_n;
        end
        if (cyc_n - diff_start[i] == DEB - 1) begin
          m_stable[i] = o_s2[i];
          diffing[i] = 1'b0;
          if (o_s2[i]) rise_edge[i] = cyc_n;
        end
      end else begin
        diffing[i] = 1'b0;
      end
    end
    m_s2 = m_s1;
    m_s1 = ~in_port;
    clr = (bus.chipselect && bus.write && bus.address == 2'd2) ? bus.writedata[NB-1:0] : '0;
    if (bus.chipselect && bus.write && bus.address == 2'd1) m_mask = bus.writedata[NB-1:0];
    m_event = (o_event & ~clr) | set;
    m_irq = |(o_event & o_mask);
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) model_reset();
    else model_step();
  end

  // ---------------- monitor ----------------
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (mon_en) begin
      chk("irq", 32'(irq), 32'(m_irq));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("readdata", bus.readdata, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    in_port        = ~pressed;
    bus.chipselect = r | w;
    bus.read       = r;
    bus.write      = w;
    bus.address    = a;
    bus.writedata  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) op(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a);
    op(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    op(1'b0, 1'b1, a, d);
  endtask

  initial begin
    int unsigned t;
    int unsigned r;
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = '0; bus.writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    chk("rst_readdata", bus.readdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    // Register map after reset
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      idle(1);
      chk("rst_reg", bus.readdata, 32'd0);
    end
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1);
    idle(1);
    chk("mask_readback", bus.readdata, 32'h0000_000F);
    wr(2'd1, 32'd0);

    // Glitch rejection: 3-cycle pulse
    pressed[0] = 1'b1;
    repeat (3) rd(2'd0);
    pressed[0] = 1'b0;
    repeat (8) rd(2'd0);
    rd(2'd2);
    idle(1);
    chk("glitch_event", bus.readdata, 32'd0);

    // Held press on button 0
    pressed[0] = 1'b1;
    repeat (10) begin rd(2'd0); rd(2'd2); end
    pressed[0] = 1'b0;
    idle(10);
    wr(2'd2, 32'hF);

    // Interrupt with mask on button 0
    wr(2'd1, 32'h1);
    pressed[0] = 1'b1;
    idle(10);
    chk("irq_set", 32'(irq), 32'd1);
    wr(2'd2, 32'h1);
    idle(2);
    chk("irq_clear", 32'(irq), 32'd0);
    pressed[0] = 1'b0;
    idle(10);

    // Masked-off button 1
    pressed[1] = 1'b1;
    idle(12);
    chk("irq_masked", 32'(irq), 32'd0);
    rd(2'd2);
    idle(1);
    chk("event_b1", bus.readdata, 32'h2);
    pressed[1] = 1'b0;
    idle(10);
    wr(2'd2, 32'hF);

    // Auto-repeat on button 2, clearing as it goes
    pressed[2] = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (k % 4 == 3) wr(2'd2, 32'h4);
      else if (k % 2 == 1) rd(2'd3);
      else rd(2'd2);
    end
    rd(2'd3);
    idle(1);
    chk("held_b2", bus.readdata, 32'h4);

    // Collision: W1C lands on the same edge as a repeat event
    t = rise_edge[2] + 1 + RD;
    while (t < cyc_n + 3) t += RP;
    while (cyc_n + 2 < t) idle(1);
    wr(2'd2, 32'h4);
    rd(2'd2);
    idle(1);
    chk("collision", bus.readdata & 32'h4, 32'h4);

    // Release button 2
    pressed[2] = 1'b0;
    repeat (12) rd(2'd3);
    wr(2'd2, 32'hF);
    repeat (20) begin rd(2'd2); rd(2'd3); end
    rd(2'd3);
    idle(1);
    chk("held_release", bus.readdata, 32'd0);

    // Reset while button 3 repeats, held through release
    wr(2'd1, 32'hF);
    pressed[3] = 1'b1;
    idle(40);
    reset_n = 1'b0;
    #1;
    chk("midrst_readdata", bus.readdata, 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    idle(3);
    reset_n = 1'b1;
    idle(9);
    rd(2'd2);
    idle(1);
    chk("rst_repress", bus.readdata, 32'h8);
    pressed[3] = 1'b0;
    idle(10);

    // Randomized traffic
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, NB - 1);
        pressed[r] = ~pressed[r];
      end
      r = $urandom_range(0, 9);
      if (r < 5) rd(2'($urandom_range(0, 3)));
      else if (r < 7) wr(2'($urandom_range(0, 3)), $urandom);
      else idle(1);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
